// File: rtl/mem_ctrl.sv
// Byte-serial RAM port controller: arbitrates instruction fetch and load/store
// traffic, sequencing 1/2/4-byte load/store accesses little-endian.
module mem_ctrl #(
   parameter int ADDR_W = 32
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              rdy_in,
   input  logic              clear,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_valid,
   output logic [7:0]        if_din,
   input  logic              ls_req,
   input  logic              ls_wr,
   input  logic [1:0]        ls_size,
   input  logic [ADDR_W-1:0] ls_addr,
   input  logic [31:0]       ls_wdata,
   output logic              ls_done,
   output logic [31:0]       ls_rdata,
   input  logic              io_buffer_full,
   input  logic [7:0]        ram_din,
   output logic [7:0]        ram_dout,
   output logic [ADDR_W-1:0] ram_a,
   output logic              ram_wr
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_IF_RUN,
      S_LS_READ,
      S_LS_WRITE,
      S_LS_DONE
   } state_t;

   state_t            r_state;
   logic [1:0]        r_k;
   logic [1:0]        r_last;
   logic              r_cap;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_wdata;
   logic              r_ls_done;
   logic [31:0]       r_ls_rdata;

   logic              w_fetch_go;
   logic              w_io_hold;
   logic [1:0]        w_last;
   logic [1:0]        w_cap_idx;
   logic [ADDR_W-1:0] w_byte_addr;
   logic [7:0]        w_wbyte;
   logic [ADDR_W-1:0] w_ram_a;
   logic              w_ram_wr;
   logic [7:0]        w_ram_dout;
   logic              w_if_valid;

   assign w_fetch_go  = if_req && !ls_req && !clear;
   assign w_io_hold   = (r_addr[17:16] == 2'b11) && io_buffer_full;
   assign w_last      = (ls_size == 2'd0) ? 2'd0 : ((ls_size == 2'd1) ? 2'd1 : 2'd3);
   assign w_byte_addr = r_addr + {{(ADDR_W-2){1'b0}}, r_k};
   assign w_wbyte     = r_wdata[{r_k, 3'b000} +: 8];
   // RAM data lags its address by one cycle, so the byte on ram_din belongs to k-1,
   // except in the trailing capture cycle where k was left at the last index.
   assign w_cap_idx   = r_cap ? r_k : (r_k - 2'd1);

   always_comb begin
      w_ram_a    = '0;
      w_ram_wr   = 1'b0;
      w_ram_dout = 8'h00;
      w_if_valid = 1'b0;
      case (r_state)
         S_IF_RUN: begin
            if (w_fetch_go) begin
               w_ram_a    = if_addr;
               w_if_valid = rdy_in;
            end
         end
         S_LS_READ: begin
            if (!r_cap) w_ram_a = w_byte_addr;
         end
         S_LS_WRITE: begin
            w_ram_a    = w_byte_addr;
            w_ram_dout = w_wbyte;
            w_ram_wr   = rdy_in && !w_io_hold;
         end
         default: ;
      endcase
   end

   assign ram_a    = w_ram_a;
   assign ram_wr   = w_ram_wr;
   assign ram_dout = w_ram_dout;
   assign if_valid = w_if_valid;
   assign if_din   = ram_din;
   assign ls_done  = r_ls_done;
   assign ls_rdata = r_ls_rdata;

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_state    <= S_IDLE;
         r_k        <= 2'd0;
         r_last     <= 2'd0;
         r_cap      <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= 32'h0;
         r_ls_done  <= 1'b0;
         r_ls_rdata <= 32'h0;
      end else if (rdy_in) begin
         r_ls_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (ls_req) begin
                  r_addr  <= ls_addr;
                  r_last  <= w_last;
                  r_wdata <= ls_wdata;
                  r_k     <= 2'd0;
                  r_cap   <= 1'b0;
                  if (ls_wr) begin
                     r_state <= S_LS_WRITE;
                  end else begin
                     r_state    <= S_LS_READ;
                     r_ls_rdata <= 32'h0;
                  end
               end else if (if_req && !clear) begin
                  r_state <= S_IF_RUN;
               end
            end
            S_IF_RUN: begin
               if (!w_fetch_go) r_state <= S_IDLE;
            end
            S_LS_READ: begin
               if (r_cap || (r_k != 2'd0)) r_ls_rdata[{w_cap_idx, 3'b000} +: 8] <= ram_din;
               if (r_cap) begin
                  r_cap     <= 1'b0;
                  r_state   <= S_LS_DONE;
                  r_ls_done <= 1'b1;
               end else if (r_k == r_last) begin
                  r_cap <= 1'b1;
               end else begin
                  r_k <= r_k + 2'd1;
               end
            end
            S_LS_WRITE: begin
               if (!w_io_hold) begin
                  if (r_k == r_last) begin
                     r_state   <= S_LS_DONE;
                     r_ls_done <= 1'b1;
                  end else begin
                     r_k <= r_k + 2'd1;
                  end
               end
            end
            S_LS_DONE: begin
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed scenarios plus randomized fetch and
// load/store episodes checked against a byte-addressed reference memory.
module tb_mem_ctrl;

   logic        clk_in = 1'b0;
   logic        rst_in, rdy_in, clear, if_req;
   logic [31:0] if_addr;
   logic        if_valid;
   logic [7:0]  if_din;
   logic        ls_req, ls_wr;
   logic [1:0]  ls_size;
   logic [31:0] ls_addr, ls_wdata;
   logic        ls_done;
   logic [31:0] ls_rdata;
   logic        io_buffer_full;
   logic [7:0]  ram_din = 8'h00;
   logic [7:0]  ram_dout;
   logic [31:0] ram_a;
   logic        ram_wr;

   int          total = 0;
   int          bad = 0;
   bit          prev_cond = 1'b0;
   bit          pend_valid = 1'b0;
   logic [31:0] pend_addr = 32'h0;

   logic [7:0]  ram_mem [logic [31:0]];
   logic [7:0]  ref_mem [logic [31:0]];

   always #5 clk_in = ~clk_in;

   mem_ctrl #(.ADDR_W(32)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
      .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_din(if_din),
      .ls_req(ls_req), .ls_wr(ls_wr), .ls_size(ls_size), .ls_addr(ls_addr),
      .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
      .io_buffer_full(io_buffer_full), .ram_din(ram_din), .ram_dout(ram_dout),
      .ram_a(ram_a), .ram_wr(ram_wr)
   );

   function automatic logic [7:0] init_byte(input logic [31:0] a);
      return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'h5A;
   endfunction

   function automatic logic [7:0] ram_rd(input logic [31:0] a);
      if (ram_mem.exists(a)) return ram_mem[a];
      return init_byte(a);
   endfunction

   function automatic logic [7:0] ref_rd(input logic [31:0] a);
      if (ref_mem.exists(a)) return ref_mem[a];
      return init_byte(a);
   endfunction

   // Synchronous RAM whose read register is gated by the global ready, like the rest of the system.
   always @(posedge clk_in) begin
      if (rdy_in) begin
         ram_din <= ram_rd(ram_a);
         if (ram_wr) ram_mem[ram_a] = ram_dout;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic preload(input logic [31:0] a, input logic [7:0] b);
      ram_mem[a] = b;
      ref_mem[a] = b;
   endtask

   task automatic sample_common();
      if (pend_valid) begin
         check_eq("if_din", {24'h0, if_din}, {24'h0, ref_rd(pend_addr)});
         pend_valid = 1'b0;
      end
   endtask

   // One fetch-side cycle: a byte is issued when the request held for this and the previous cycle.
   task automatic fetch_step(input bit req, input logic [31:0] addr, input bit clr);
      bit cond, exp;
      @(posedge clk_in); #1;
      if_req = req; if_addr = addr; clear = clr; ls_req = 1'b0; rdy_in = 1'b1;
      io_buffer_full = 1'($urandom_range(0, 1));
      @(negedge clk_in);
      sample_common();
      cond = req && !clr;
      exp  = cond && prev_cond;
      check_eq("if_valid", {31'h0, if_valid}, {31'h0, exp});
      check_eq("if_ram_a", ram_a, exp ? addr : 32'h0);
      check_eq("if_ram_wr", {31'h0, ram_wr}, 32'h0);
      check_eq("if_ls_done", {31'h0, ls_done}, 32'h0);
      pend_valid = exp;
      pend_addr  = addr;
      prev_cond  = cond;
   endtask

   // One load/store transaction; 'remaining' counts productive cycles left until the done cycle.
   task automatic ls_episode(input bit wr, input logic [1:0] size, input logic [31:0] addr,
                             input logic [31:0] wdata, input bit preempt, input bit rnd,
                             input int stall_at, input int io_hold_n);
      int n, remaining, c;
      bit io_reg, held, exp_wr;
      logic [31:0] exp_a, exp_rd;
      logic [39:0] wq[$];
      n = (size == 2'd0) ? 1 : ((size == 2'd1) ? 2 : 4);
      remaining = (wr ? n + 1 : n + 2) + int'(preempt);
      io_reg = (addr[17:16] == 2'b11);
      c = 0;
      forever begin
         @(posedge clk_in); #1;
         ls_req = 1'b1; ls_wr = wr; ls_size = size; ls_addr = addr; ls_wdata = wdata;
         if (rnd) begin
            rdy_in = ($urandom_range(0, 4) != 0);
            io_buffer_full = ($urandom_range(0, 2) == 0);
            clear = ($urandom_range(0, 3) == 0);
            if_req = 1'($urandom_range(0, 1));
            if_addr = $urandom;
         end else begin
            rdy_in = !(stall_at >= 0 && c >= stall_at && c < stall_at + 2);
            io_buffer_full = (c <= io_hold_n);
            clear = 1'b1;
            if_req = preempt;
         end
         if (remaining == 0) rdy_in = 1'b1;
         @(negedge clk_in);
         sample_common();
         exp_a = 32'h0;
         exp_wr = 1'b0;
         held = 1'b0;
         if (!wr && remaining >= 2 && remaining <= n + 1) exp_a = addr + 32'(n + 1 - remaining);
         if (wr && remaining >= 1 && remaining <= n) begin
            exp_a  = addr + 32'(n - remaining);
            held   = io_reg && io_buffer_full;
            exp_wr = rdy_in && !held;
         end
         check_eq("ls_ram_a", ram_a, exp_a);
         check_eq("ls_ram_wr", {31'h0, ram_wr}, {31'h0, exp_wr});
         check_eq("ls_if_valid", {31'h0, if_valid}, 32'h0);
         check_eq("ls_done", {31'h0, ls_done}, {31'h0, (remaining == 0)});
         if (ram_wr) wq.push_back({ram_dout, ram_a});
         if (remaining == 0) break;
         if (rdy_in && !held) remaining--;
         c++;
         if (c > 300) begin
            check_eq("ls_budget", 32'(c), 32'd300);
            break;
         end
      end
      if (!wr) begin
         exp_rd = 32'h0;
         for (int i = 0; i < n; i++) exp_rd[8*i +: 8] = ref_rd(addr + 32'(i));
         check_eq("ls_rdata", ls_rdata, exp_rd);
      end else begin
         check_eq("st_count", 32'(wq.size()), 32'(n));
         for (int i = 0; i < n && i < wq.size(); i++) begin
            check_eq("st_addr", wq[i][31:0], addr + 32'(i));
            check_eq("st_data", {24'h0, wq[i][39:32]}, {24'h0, wdata[8*i +: 8]});
         end
         for (int i = 0; i < n; i++) ref_mem[addr + 32'(i)] = wdata[8*i +: 8];
      end
      $display("ls %s bytes=%0d addr=0x%08h data=0x%08h cycles=%0d",
               wr ? "store" : "load ", n, addr, wr ? wdata : ls_rdata, c + 1);
      prev_cond  = 1'b0;
      pend_valid = 1'b0;
   endtask

   function automatic logic [31:0] rand_addr();
      logic [31:0] bases [3];
      bases[0] = 32'h0000_0100;
      bases[1] = 32'h0003_0010;
      bases[2] = 32'hFFFF_FFFC;
      return bases[$urandom_range(0, 2)] + 32'($urandom_range(0, 7));
   endfunction

   initial begin
      rst_in = 1'b0; rdy_in = 1'b1; clear = 1'b0; if_req = 1'b0; if_addr = 32'h0;
      ls_req = 1'b0; ls_wr = 1'b0; ls_size = 2'd0; ls_addr = 32'h0; ls_wdata = 32'h0;
      io_buffer_full = 1'b0;
      preload(32'h100, 8'h11); preload(32'h101, 8'h22);
      preload(32'h102, 8'h33); preload(32'h103, 8'h44);
      repeat (3) @(posedge clk_in);
      @(negedge clk_in);
      check_eq("rst_ram_a", ram_a, 32'h0);
      check_eq("rst_ram_wr", {31'h0, ram_wr}, 32'h0);
      check_eq("rst_if_valid", {31'h0, if_valid}, 32'h0);
      check_eq("rst_ls_done", {31'h0, ls_done}, 32'h0);
      check_eq("rst_ls_rdata", ls_rdata, 32'h0);
      @(posedge clk_in); #1 rst_in = 1'b1;

      ls_episode(1'b0, 2'd2, 32'h100, 32'h0, 1'b0, 1'b0, -1, 0);
      check_eq("word_load_0x100", ls_rdata, 32'h4433_2211);
      ls_episode(1'b1, 2'd1, 32'h2001, 32'h0000_BEEF, 1'b0, 1'b0, -1, 0);

      // Fetch streaming from 0, preempted by a load, then resumed.
      fetch_step(1'b1, 32'h0, 1'b0);
      fetch_step(1'b1, 32'h1, 1'b0);
      fetch_step(1'b1, 32'h2, 1'b0);
      ls_episode(1'b0, 2'd0, 32'h2002, 32'h0, prev_cond, 1'b0, -1, 0);
      fetch_step(1'b1, 32'h3, 1'b0);
      fetch_step(1'b1, 32'h4, 1'b0);
      fetch_step(1'b1, 32'h5, 1'b0);
      fetch_step(1'b0, 32'h6, 1'b0);

      ls_episode(1'b1, 2'd0, 32'h0003_0000, 32'h0000_005C, 1'b0, 1'b0, -1, 3);

      fetch_step(1'b1, 32'h40, 1'b0);
      fetch_step(1'b1, 32'h41, 1'b0);
      fetch_step(1'b1, 32'h42, 1'b1);
      fetch_step(1'b1, 32'h43, 1'b0);
      fetch_step(1'b1, 32'h44, 1'b0);
      fetch_step(1'b0, 32'h45, 1'b0);

      ls_episode(1'b1, 2'd2, 32'h600, 32'hCAFE_F00D, 1'b0, 1'b0, -1, 0);
      ls_episode(1'b0, 2'd2, 32'h600, 32'h0, 1'b0, 1'b0, -1, 0);
      ls_episode(1'b0, 2'd2, 32'h100, 32'h0, 1'b0, 1'b0, 2, 0);

      // Reset in the middle of a word store: only byte 0 reaches the RAM.
      @(posedge clk_in); #1;
      ls_req = 1'b1; ls_wr = 1'b1; ls_size = 2'd2; ls_addr = 32'h500; ls_wdata = 32'hA1B2_C3D4;
      rdy_in = 1'b1; clear = 1'b0; if_req = 1'b0; io_buffer_full = 1'b0;
      @(posedge clk_in);
      @(posedge clk_in); #1;
      check_eq("mid_store_wr", {31'h0, ram_wr}, 32'h1);
      check_eq("mid_store_a", ram_a, 32'h501);
      #2 rst_in = 1'b0;
      #1;
      check_eq("rst_mid_ram_wr", {31'h0, ram_wr}, 32'h0);
      check_eq("rst_mid_ram_a", ram_a, 32'h0);
      check_eq("rst_mid_ram_dout", {24'h0, ram_dout}, 32'h0);
      check_eq("rst_mid_ls_done", {31'h0, ls_done}, 32'h0);
      ls_req = 1'b0;
      @(posedge clk_in); #1 rst_in = 1'b1;
      ref_mem[32'h500] = 8'hD4;
      prev_cond = 1'b0;
      pend_valid = 1'b0;
      ls_episode(1'b0, 2'd2, 32'h500, 32'h0, 1'b0, 1'b0, -1, 0);

      for (int e = 0; e < 60; e++) begin
         if ($urandom_range(0, 1) == 0) begin
            logic [31:0] base;
            int len;
            base = rand_addr();
            len = $urandom_range(2, 8);
            for (int i = 0; i < len; i++)
               fetch_step($urandom_range(0, 5) != 0, base + 32'(i), $urandom_range(0, 7) == 0);
         end else begin
            ls_episode(1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)), rand_addr(),
                       $urandom, prev_cond, 1'b1, -1, 0);
         end
      end
      fetch_step(1'b0, 32'h0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1, "time limit");
   end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Byte-serial memory controller between the single 8-bit RAM port and its two clients: the instruction fetch unit (one byte per cycle, fetch-driven addressing) and the load/store buffer (1/2/4-byte transactions). It arbitrates the port, with load/store priority, and sequences multi-byte accesses little-endian. It holds I/O-region writes while the I/O buffer is full and freezes on `rdy_in` low.

## Interface
- `ADDR_W`, 32, address width of all address ports
- `clk_in`  in  1  clock
- `rst_in`  in  1  reset, asynchronous, active-low
- `rdy_in`  in  1  global ready; low freezes the block
- `clear`  in  1  control hazard; aborts fetch only
- `if_req`  in  1  fetch wants a byte this cycle
- `if_addr`  in  ADDR_W  fetch byte address
- `if_valid`  out  1  fetch byte issued this cycle; data arrives on `if_din` next cycle
- `if_din`  out  8  equals `ram_din`
- `ls_req`  in  1  load/store request; held until `ls_done`
- `ls_wr`  in  1  1 = store, 0 = load
- `ls_size`  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal
- `ls_addr`  in  ADDR_W  base address
- `ls_wdata`  in  32  store data, bits [7:0] at `ls_addr`
- `ls_done`  out  1  one-cycle completion pulse
- `ls_rdata`  out  32  load data, zero-extended, valid with `ls_done`
- `io_buffer_full`  in  1  I/O output buffer full
- `ram_din`  in  8  RAM read data, one cycle after its address
- `ram_dout`  out  8  RAM write data
- `ram_a`  out  ADDR_W  RAM address
- `ram_wr`  out  1  1 = write, 0 = read

## Operation
- States: IDLE, IF_RUN, LS_READ, LS_WRITE, LS_DONE. Byte counter `k` is 2 bits. `n` = 1, 2 or 4 bytes from `ls_size`.
- Registered: state, `k`, latched addr/size/wdata/wr, `ls_done`, `ls_rdata`. Combinational from state and inputs: `ram_a`, `ram_wr`, `ram_dout`, `if_valid`.
- IDLE:
  - Port idle: `ram_a`=0, `ram_wr`=0.
  - If `ls_req`: latch the request, set `k`=0, go to LS_WRITE or LS_READ.
  - Else if `if_req && !clear`: go to IF_RUN.
- IF_RUN:
  - When `if_req && !ls_req && !clear`: drive `ram_a`=`if_addr`, `ram_wr`=0, `if_valid`=1, stay.
  - Otherwise: `if_valid`=0, no access, go to IDLE. A pending load/store therefore preempts fetch between any two bytes.
- LS_READ:
  - Drive `ram_a`=addr+`k`.
  - Byte `k-1` captured from `ram_din` into `ls_rdata[8(k-1)+:8]` when `k`>0.
  - After the address for `k`=n-1, spend one extra cycle with the port idle to capture the last byte, then go to LS_DONE.
  - Before the first byte, clear the unused upper `ls_rdata` bytes to 0.
- LS_WRITE:
  - Drive `ram_a`=addr+`k`, `ram_wr`=1, `ram_dout`=wdata byte `k`.
  - Go to LS_DONE after `k`=n-1.
  - I/O hold: if addr[17:16]==2'b11 and `io_buffer_full`=1, force `ram_wr`=0 and hold `k` that cycle.
- LS_DONE:
  - `ls_done`=1 for this cycle only, port idle, `ls_req` ignored, go to IDLE next.
  - The LSB must drop or replace `ls_req` on the edge that ends LS_DONE.
- `clear`: affects IDLE/IF_RUN only. Load/store transactions always run to completion.
- Address arithmetic wraps modulo 2^ADDR_W.
- `rdy_in`=0: hold all registers; force `ram_wr`=0 and `if_valid`=0.
- Reset: state IDLE, `k`=0, `ls_done`=0, `ls_rdata`=0. All combinational outputs are therefore 0.
- Reset asserted mid-transaction abandons it immediately; a partially written store is not completed.

## Timing
- Fetch entry costs one IDLE cycle, then one byte per cycle.
- `if_valid` high in cycle t → byte on `ram_din`/`if_din` in cycle t+1.
- Load of n bytes, with `ls_req` sampled in IDLE at edge E0:
  - Addresses in cycles 1..n.
  - Capture cycle n+1.
  - `ls_done` high in cycle n+2.
  - Word load: 6 cycles from request to done.
- Store of n bytes: writes in cycles 1..n, `ls_done` in cycle n+1, plus any I/O hold cycles.
- Back-to-back load/store: the earliest next acceptance is the IDLE cycle after LS_DONE.

## Test plan
- Word load at 0x100, RAM bytes 11 22 33 44 → `ram_a` 0x100..0x103 in cycles 1–4, `ls_done` in cycle 6, `ls_rdata`=0x44332211.
- Half store 0xBEEF to 0x2001 → `ram_wr`=1 at 0x2001 (EF) then 0x2002 (BE), `ls_done` next cycle; `ram_wr` low otherwise.
- Fetch streaming from 0x0; `ls_req` raised in the 3rd fetch cycle → `if_valid` high for exactly 2 cycles then drops, load runs, IF_RUN resumes after LS_DONE and IDLE.
- Byte store to 0x30000 with `io_buffer_full` high for 3 cycles → `ram_wr` low for 3 cycles, write in the 4th, then `ls_done`.
- `clear` during IF_RUN → `if_valid`=0 that cycle and state IDLE. `clear` during a word store → all 4 bytes written.
- `rdy_in` low for 2 cycles mid word-load → `ram_wr`=0, `k` frozen, `ls_done` delayed by exactly 2 cycles. `rst_in` low mid-store → all outputs 0 immediately.
